// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// frame-format constants.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        PAYLOAD,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int HDR_LEN = 2;
    localparam int CSUM_W  = 8;

endpackage

// File: rtl/imem_word_packer.sv
// Packs an accepted byte stream into 32-bit little-endian words; word_ready
// flags the cycle in which the fourth byte of a word is accepted.
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  lane;
    logic [31:0] word_q;

    // Bytes enter at the top and shift down, so after four bytes the first
    // one sits in lane 0 (least-significant byte).
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            lane   <= 2'd0;
            word_q <= 32'd0;
        end else if (byte_en) begin
            word_q <= {byte_in, word_q[31:8]};
            lane   <= lane + 2'd1;
        end
    end

    assign word       = word_q;
    assign word_ready = byte_en && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a framed, checksummed byte image, writes it into
// instruction memory and releases the core reset once the image verifies.
module imem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             instr_wr_e,
    output logic [31:0]      instr_addr,
    output logic [31:0]      instr_data,
    output logic             cpu_rst_n,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  wc_q;
    logic [CSUM_W-1:0] sum_q;
    logic [CSUM_W-1:0] sum_next;
    logic [31:0]       addr_q;
    logic [CNT_W-1:0]  len_full;
    logic              xfer;
    logic              start_ok;
    logic              word_ready;
    logic [31:0]       packed_word;

    assign byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                        (state_q == PAYLOAD) || (state_q == CHECK);
    assign xfer       = byte_valid && byte_ready;
    assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE) ||
                                  (state_q == ERROR));
    assign sum_next   = sum_q + CSUM_W'(byte_in);
    assign len_full   = CNT_W'({byte_in, len_q[7:0]});

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_en    (xfer && (state_q == PAYLOAD)),
        .byte_in    (byte_in),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERROR: if (start) state_d = LEN_LO;
            LEN_LO:  if (xfer) state_d = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if (len_full > MAX_N)          state_d = ERROR;
                    else if (len_full == '0)       state_d = CHECK;
                    else                           state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (word_ready) state_d = WRITE;
            WRITE:   state_d = (wc_q + CNT_W'(1) == len_q) ? CHECK : PAYLOAD;
            CHECK: begin
                if (xfer) state_d = (sum_next == '0) ? DONE : ERROR;
            end
            default: state_d = IDLE;
        endcase
    end

    // The write address is captured with the fourth byte so it stays stable
    // through the write and holds afterwards while word_count moves on.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q  <= '0;
            wc_q   <= '0;
            len_q  <= '0;
            addr_q <= BASE_ADDR;
        end else begin
            if (start_ok) begin
                sum_q <= '0;
                wc_q  <= '0;
            end else begin
                if (xfer)              sum_q <= sum_next;
                if (state_q == WRITE)  wc_q  <= wc_q + CNT_W'(1);
            end
            if (xfer && (state_q == LEN_LO)) len_q[7:0] <= byte_in;
            if (xfer && (state_q == LEN_HI)) len_q      <= len_full;
            if (word_ready) addr_q <= BASE_ADDR + (32'(wc_q) << 2);
        end
    end

    assign instr_wr_e = (state_q == WRITE);
    assign instr_addr = addr_q;
    assign instr_data = packed_word;
    assign cpu_rst_n  = (state_q == DONE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);
    assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames driven with varied
// byte_valid patterns, checked against a frame-level model of the loader.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        instr_wr_e;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        cpu_rst_n;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .instr_wr_e (instr_wr_e),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        bit nop;
        bit bad;
        int mode;
        bit exp_done;
        bit exp_error;
    } vec_t;

    vec_t         vecs[9];
    logic [7:0]   frame_q[$];
    logic [31:0]  exp_words[$];
    logic [63:0]  got[$];
    int           checks = 0;
    int           errors = 0;
    bit           prev_done = 1'b0;

    always @(negedge clk) begin
        if (instr_wr_e === 1'b1) got.push_back({instr_addr, instr_data});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: header, little-endian payload, checksum that makes the
    // byte sum zero (plus one when a corrupt checksum is wanted).
    task automatic build_frame(input int n, input bit nop, input bit bad);
        int s;
        logic [31:0] w;
        frame_q.delete();
        exp_words.delete();
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        if (n <= MAXW) begin
            for (int k = 0; k < n; k++) begin
                w = nop ? 32'h0000_0013 : $urandom;
                exp_words.push_back(w);
                for (int b = 0; b < 4; b++) frame_q.push_back(w[8*b +: 8]);
            end
        end
        s = 0;
        foreach (frame_q[i]) s += int'(frame_q[i]);
        s = (256 - (s % 256) + (bad ? 1 : 0)) % 256;
        frame_q.push_back(s[7:0]);
    endtask

    task automatic send_bytes(input int nsend, input int mode);
        int  i = 0;
        int  cyc = 0;
        bit  hold = 1'b0;
        int  budget = 20 * nsend + 50;
        while (i < nsend && cyc < budget) begin
            @(negedge clk);
            if (!hold) begin
                case (mode)
                    0:       byte_valid = 1'b1;
                    1:       byte_valid = (cyc % 2 == 0);
                    default: byte_valid = 1'($urandom_range(0, 1));
                endcase
            end
            byte_in = byte_valid ? frame_q[i] : 8'($urandom);
            if (byte_valid && byte_ready) begin
                i++;
                hold = 1'b0;
            end else begin
                hold = byte_valid;
            end
            cyc++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        if (i < nsend) chk("send_timeout", 64'(i), 64'(nsend));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        got.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input int idx);
        vec_t v = vecs[idx];
        int   nsend;
        int   c;
        build_frame(v.n, v.nop, v.bad);
        nsend = (v.n > MAXW) ? 2 : frame_q.size();
        @(negedge clk);
        chk($sformatf("v%0d_pre_cpu_rst_n", idx), 64'(cpu_rst_n), 64'(prev_done));
        pulse_start();
        chk($sformatf("v%0d_start_cpu_rst_n", idx), 64'(cpu_rst_n), 64'd0);
        chk($sformatf("v%0d_start_status", idx), 64'({done, error}), 64'd0);
        send_bytes(nsend, v.mode);
        c = 0;
        while (c < 10 && !(done || error)) begin
            @(negedge clk);
            c++;
        end
        if (!(done || error)) chk($sformatf("v%0d_finish_timeout", idx), 64'd0, 64'd1);
        chk($sformatf("v%0d_done", idx), 64'(done), 64'(v.exp_done));
        chk($sformatf("v%0d_error", idx), 64'(error), 64'(v.exp_error));
        chk($sformatf("v%0d_cpu_rst_n", idx), 64'(cpu_rst_n), 64'(v.exp_done));
        chk($sformatf("v%0d_byte_ready", idx), 64'(byte_ready), 64'd0);
        chk($sformatf("v%0d_word_count", idx), 64'(word_count), 64'(exp_words.size()));
        chk($sformatf("v%0d_nwrites", idx), 64'(got.size()), 64'(exp_words.size()));
        for (int k = 0; k < exp_words.size(); k++) begin
            if (k < got.size())
                chk($sformatf("v%0d_write%0d", idx, k), got[k], {BASE + 32'(4 * k), exp_words[k]});
            else
                chk($sformatf("v%0d_write%0d_missing", idx, k), 64'd0, 64'd1);
        end
        prev_done = v.exp_done;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        chk({tag, "_wr_e"},       64'(instr_wr_e), 64'd0);
        chk({tag, "_addr"},       64'(instr_addr), 64'(BASE));
        chk({tag, "_data"},       64'(instr_data), 64'd0);
        chk({tag, "_cpu_rst_n"},  64'(cpu_rst_n),  64'd0);
        chk({tag, "_done"},       64'(done),       64'd0);
        chk({tag, "_error"},      64'(error),      64'd0);
        chk({tag, "_word_count"}, 64'(word_count), 64'd0);
    endtask

    initial begin
        //        n    nop  bad  mode done error
        vecs[0] = '{1,   1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[1] = '{3,   1'b0, 1'b0, 1, 1'b1, 1'b0};
        vecs[2] = '{2,   1'b0, 1'b1, 0, 1'b0, 1'b1};
        vecs[3] = '{257, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        vecs[4] = '{0,   1'b0, 1'b0, 0, 1'b1, 1'b0};
        vecs[5] = '{1,   1'b0, 1'b0, 0, 1'b1, 1'b0};
        vecs[6] = '{5,   1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[7] = '{4,   1'b0, 1'b1, 2, 1'b0, 1'b1};
        vecs[8] = '{256, 1'b0, 1'b0, 0, 1'b1, 1'b0};

        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_frame(i);

        // Abort in the middle of the second payload word.
        build_frame(2, 1'b0, 1'b0);
        pulse_start();
        send_bytes(8, 0);
        rst        = 1'b0;
        byte_valid = 1'b1;
        byte_in    = frame_q[8];
        @(negedge clk);
        chk_reset_values("abort");
        chk("abort_writes_before", 64'(got.size()), 64'd1);
        if (got.size() > 0) chk("abort_write0", got[0], {BASE, exp_words[0]});
        repeat (3) @(negedge clk);
        chk("abort_writes_after", 64'(got.size()), 64'd1);
        chk("abort_ready_held", 64'(byte_ready), 64'd0);
        rst        = 1'b1;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_idle_ready", 64'(byte_ready), 64'd0);
        chk("abort_idle_writes", 64'(got.size()), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Upstream program loader for the single-cycle core.
- Accepts a framed byte stream over a valid/ready handshake and packs bytes into 32-bit little-endian words.
- Writes each word into instruction memory through its write port at consecutive addresses.
- Holds the core in reset until a complete, checksum-verified image is loaded.

Parameters:
- BASE_ADDR, 32'h0000_0000, instruction-memory byte address of the first loaded word.
- MAX_WORDS, 256, largest accepted image length in words; larger headers are rejected.
- CNT_W, 16, width of the length field and the word counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader can accept a byte.
- instr_wr_e  out  1  instruction-memory write enable.
- instr_addr  out  32  instruction-memory write address (byte address, word aligned).
- instr_data  out  32  instruction-memory write data.
- cpu_rst_n  out  1  core reset, active-low; low until a load succeeds.
- done  out  1  image loaded and verified.
- error  out  1  length or checksum fault.
- word_count  out  CNT_W  number of words written in the current load.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE.
  - byte_ready=0, instr_wr_e=0, instr_addr=BASE_ADDR, instr_data=0.
  - cpu_rst_n=0, done=0, error=0, word_count=0.
  - Reset mid-load aborts immediately; no further writes are issued.
- Byte transfer occurs only on a cycle where byte_valid && byte_ready.
  - byte_ready=1 only in LEN_LO, LEN_HI, PAYLOAD and CHECK.
  - The loader never drops a byte it has accepted.
- Frame format:
  - Length low byte, then length high byte: N words.
  - 4N payload bytes, least-significant byte of each word first.
  - One checksum byte.
  - The 8-bit modular sum of all frame bytes, including the length bytes and the checksum byte, must equal 0.
- State machine:
  - IDLE: on start go to LEN_LO; clear the running sum, word_count, done and error; cpu_rst_n=0.
  - LEN_LO: on transfer, latch N[7:0] and go to LEN_HI.
  - LEN_HI: on transfer, latch N[15:8], then:
    - N > MAX_WORDS: go to ERROR.
    - N = 0: go to CHECK.
    - otherwise: go to PAYLOAD.
  - PAYLOAD: shift each accepted byte into byte lane k (k = 0..3). When the 4th byte is accepted, go to WRITE.
  - WRITE: exactly one cycle.
    - instr_wr_e=1, instr_addr=BASE_ADDR+4*word_count, instr_data=assembled word; byte_ready=0.
    - At the end of the cycle, word_count increments.
    - If the new word_count equals N, go to CHECK; otherwise return to PAYLOAD.
  - CHECK: on transfer, add the byte to the sum. If the sum is 0, go to DONE; otherwise go to ERROR.
  - DONE: done=1, cpu_rst_n=1; start restarts the load.
  - ERROR: error=1, cpu_rst_n=0; start restarts the load.
- Latency: the word write is asserted in the cycle immediately after its 4th byte is accepted. Minimum rate is 5 cycles per word.
- The running sum is 8 bits and wraps modulo 256. word_count never exceeds MAX_WORDS.
- start is ignored in LEN_LO through CHECK.
- byte_valid seen in IDLE, WRITE, DONE or ERROR is not consumed.
- instr_addr holds its last value when instr_wr_e=0.
- Restarting from DONE pulls cpu_rst_n low in the cycle after start.

Decomposition:
- Shared package loader_pkg holds:
  - the state encoding (IDLE, LEN_LO, LEN_HI, PAYLOAD, WRITE, CHECK, DONE, ERROR);
  - the header length constant (2);
  - the checksum width (8).
- One natural sub-module, imem_word_packer: byte-lane shift register plus lane counter, with a word_ready flag and a clear input.

Test Plan:
- N=1; payload 13,00,00,00 (addi x0 as 0x00000013); checksum 0xEC → one write with addr=0x0, data=0x00000013; then done=1, cpu_rst_n=1, word_count=1.
- N=3 with byte_valid toggled every other cycle → writes at 0x0, 0x4, 0x8 with the correct little-endian words; no byte lost or duplicated.
- N=2 with a bad checksum (correct value +1) → both writes occur; error=1, done=0, cpu_rst_n stays 0.
- Length 0x0101 (257 > MAX_WORDS) → ERROR immediately after LEN_HI; no instr_wr_e ever asserted.
- N=0 with checksum 0x00 → DONE with word_count=0 and no writes. Then start plus a new N=1 frame → cpu_rst_n low next cycle; reload writes at 0x0.
- rst=0 asserted during the 2nd payload word → next cycle all outputs at reset values; no further writes.
